// File: rtl/wb_pkg.sv
// Shared constants and payload types for the writeback result arbiter.
package wb_pkg;

  localparam int unsigned FU_ARRAY   = 3;
  localparam int unsigned FU_SIZE    = 2;
  localparam int unsigned AR_SIZE    = 7;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef logic [FU_SIZE-1:0] fu_idx_t;

  typedef struct packed {
    logic [AR_SIZE-1:0] tag;
    logic [DATA_W-1:0]  value;
  } wb_entry_t;

  // Round-robin successor: the slot after the last winner, wrapping at FU_ARRAY.
  function automatic fu_idx_t rr_next(input fu_idx_t idx);
    return (32'(idx) == FU_ARRAY - 1) ? '0 : idx + FU_SIZE'(1);
  endfunction

endpackage

// File: rtl/wb_result_arbiter_if.sv
// FU result inputs and result-bus outputs of the writeback arbiter.
interface wb_result_arbiter_if;
  import wb_pkg::*;

  logic                        flush_in;
  logic [FU_ARRAY-1:0]         fu_valid_in;
  logic [FU_ARRAY*AR_SIZE-1:0] fu_tag_in;
  logic [FU_ARRAY*DATA_W-1:0]  fu_value_in;
  logic [FU_ARRAY-1:0]         fu_ready_out;
  logic                        cdb_valid_out;
  logic [AR_SIZE-1:0]          cdb_tag_out;
  logic [DATA_W-1:0]           cdb_value_out;
  logic [FU_SIZE-1:0]          cdb_fu_out;
  logic                        overflow_out;

  modport slave (
    input  flush_in, fu_valid_in, fu_tag_in, fu_value_in,
    output fu_ready_out, cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_fu_out, overflow_out
  );

  modport master (
    output flush_in, fu_valid_in, fu_tag_in, fu_value_in,
    input  fu_ready_out, cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_fu_out, overflow_out
  );
endinterface

// File: rtl/wb_result_fifo.sv
// Per-FU result FIFO with synchronous flush; pointers wrap mod DEPTH (power of 2).
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/wb_result_arbiter.sv
// Writeback arbiter: buffers FU results and broadcasts one (tag, value) per cycle, round-robin.
// Define WB_BYPASS_EN to let an input hitting an empty FIFO compete in the same cycle.
module wb_result_arbiter
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  wb_result_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t           in_entry [FU_ARRAY];
  wb_entry_t           head     [FU_ARRAY];
  logic [CNT_W-1:0]    count    [FU_ARRAY];
  logic [FU_ARRAY-1:0] empty, in_ok, has_room, eligible, win_sel, push, pop;

  logic      found;
  fu_idx_t   win_idx;
  wb_entry_t win_entry;

  fu_idx_t   rr_q, rr_d;
  logic      cdb_valid_q, cdb_valid_d;
  wb_entry_t cdb_entry_q, cdb_entry_d;
  fu_idx_t   cdb_fu_q, cdb_fu_d;
  logic      overflow_q, overflow_d;

  for (genvar i = 0; i < FU_ARRAY; i++) begin : g_fu
    assign in_entry[i].tag   = bus.fu_tag_in[i*AR_SIZE +: AR_SIZE];
    assign in_entry[i].value = bus.fu_value_in[i*DATA_W +: DATA_W];
    // Tag 0 is the hardwired zero register: never buffered, never broadcast.
    assign in_ok[i]    = bus.fu_valid_in[i] && (in_entry[i].tag != '0) && !bus.flush_in;
    assign has_room[i] = (count[i] < CNT_W'(FIFO_DEPTH));
    assign win_sel[i]  = found && (win_idx == FU_SIZE'(i));
    assign pop[i]      = win_sel[i] && !empty[i] && !bus.flush_in;
`ifdef WB_BYPASS_EN
    assign push[i]     = in_ok[i] && has_room[i] && !(win_sel[i] && empty[i]);
`else
    assign push[i]     = in_ok[i] && has_room[i];
`endif

    wb_result_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush_in),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_entry[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .count (count[i])
    );
  end

`ifdef WB_BYPASS_EN
  assign eligible = ~empty | in_ok;
`else
  assign eligible = ~empty;
`endif

  // Round-robin search starting at rr_q.
  always_comb begin
    fu_idx_t cand;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < FU_ARRAY; k++) begin
      cand = FU_SIZE'((32'(rr_q) + k) % FU_ARRAY);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_entry = head[win_idx];
`ifdef WB_BYPASS_EN
    if (empty[win_idx]) win_entry = in_entry[win_idx];
`endif
  end

  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_entry_d = cdb_entry_q;
    cdb_fu_d    = cdb_fu_q;
    overflow_d  = overflow_q || |(in_ok & ~has_room);
    if (bus.flush_in) begin
      rr_d = '0;
    end else if (found) begin
      rr_d        = rr_next(win_idx);
      cdb_valid_d = 1'b1;
      cdb_entry_d = win_entry;
      cdb_fu_d    = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_entry_q <= '0;
      cdb_fu_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_entry_q <= cdb_entry_d;
      cdb_fu_q    <= cdb_fu_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.fu_ready_out  = has_room;
  assign bus.cdb_valid_out = cdb_valid_q;
  assign bus.cdb_tag_out   = cdb_entry_q.tag;
  assign bus.cdb_value_out = cdb_entry_q.value;
  assign bus.cdb_fu_out    = cdb_fu_q;
  assign bus.overflow_out  = overflow_q;

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter (default build, bypass disabled).
module tb_wb_result_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_result_arbiter_if bus ();

  wb_result_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {valid, fu, tag, value} snapshot of the result bus.
  function automatic logic [41:0] cdb_now();
    return {bus.cdb_valid_out, bus.cdb_fu_out, bus.cdb_tag_out, bus.cdb_value_out};
  endfunction

  function automatic logic [41:0] cdb_exp(input logic [1:0] fu, input logic [6:0] tag,
                                          input logic [31:0] val);
    return {1'b1, fu, tag, val};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fu_valid_in = '0;
    bus.fu_tag_in   = '0;
    bus.fu_value_in = '0;
  endtask

  task automatic set_fu(input int fu, input logic [6:0] tag, input logic [31:0] val);
    bus.fu_valid_in[fu]        = 1'b1;
    bus.fu_tag_in[fu*7 +: 7]   = tag;
    bus.fu_value_in[fu*32 +: 32] = val;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush_in = 1'b0;
    clear_inputs();
    #12;
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.cdb_valid_out); end
    checks++; if (bus.fu_ready_out !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b exp 111", bus.fu_ready_out); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b exp 0", bus.overflow_out); end
    checks++; if (cdb_now() !== 42'd0) begin errors++; $display("FAIL reset_cdb: got %h exp 0", cdb_now()); end
    @(posedge clk); #1; rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_fu(1, 7'd5, 32'hDEAD_BEEF);
    step();
    clear_inputs();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL single_lat1: got %b exp 0", bus.cdb_valid_out); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd1, 7'd5, 32'hDEAD_BEEF)) begin errors++; $display("FAIL single_cdb: got %h exp %h", cdb_now(), cdb_exp(2'd1, 7'd5, 32'hDEAD_BEEF)); end
    step();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL single_once: got %b exp 0", bus.cdb_valid_out); end
  endtask

  task automatic test_all_fus();
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    set_fu(0, 7'd10, 32'd100); set_fu(1, 7'd11, 32'd101); set_fu(2, 7'd12, 32'd102);
    step();
    clear_inputs();
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd0, 7'd10, 32'd100)) begin errors++; $display("FAIL all_fu0: got %h exp %h", cdb_now(), cdb_exp(2'd0, 7'd10, 32'd100)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd1, 7'd11, 32'd101)) begin errors++; $display("FAIL all_fu1: got %h exp %h", cdb_now(), cdb_exp(2'd1, 7'd11, 32'd101)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd12, 32'd102)) begin errors++; $display("FAIL all_fu2: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd12, 32'd102)); end
    // Pointer wrapped to 0: FU0 beats FU2 when both push together.
    set_fu(0, 7'd20, 32'd200); set_fu(2, 7'd22, 32'd202);
    step();
    clear_inputs();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL all_gap: got %b exp 0", bus.cdb_valid_out); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd0, 7'd20, 32'd200)) begin errors++; $display("FAIL all_wrap0: got %h exp %h", cdb_now(), cdb_exp(2'd0, 7'd20, 32'd200)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd22, 32'd202)) begin errors++; $display("FAIL all_wrap2: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd22, 32'd202)); end
    step();
  endtask

  task automatic test_tag_zero();
    set_fu(0, 7'd0, 32'h1234);
    step();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL tag0_nobcast%0d: got %b exp 0", c, bus.cdb_valid_out); end
    end
    checks++; if (bus.fu_ready_out !== 3'b111) begin errors++; $display("FAIL tag0_ready: got %b exp 111", bus.fu_ready_out); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL tag0_overflow: got %b exp 0", bus.overflow_out); end
  endtask

  task automatic test_back_to_back();
    set_fu(2, 7'd40, 32'd400);
    step();
    set_fu(2, 7'd41, 32'd401);
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd40, 32'd400)) begin errors++; $display("FAIL b2b_0: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd40, 32'd400)); end
    checks++; if (bus.fu_ready_out[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", bus.fu_ready_out[2]); end
    set_fu(2, 7'd42, 32'd402);
    step();
    clear_inputs();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd41, 32'd401)) begin errors++; $display("FAIL b2b_1: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd41, 32'd401)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd42, 32'd402)) begin errors++; $display("FAIL b2b_2: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd42, 32'd402)); end
    step();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", bus.cdb_valid_out); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b exp 0", bus.overflow_out); end
  endtask

  task automatic test_overflow();
    set_fu(0, 7'd50, 32'd500); set_fu(1, 7'd51, 32'd501); set_fu(2, 7'd52, 32'd502);
    step();
    clear_inputs();
    set_fu(2, 7'd53, 32'd503);
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd0, 7'd50, 32'd500)) begin errors++; $display("FAIL ovf_fu0: got %h exp %h", cdb_now(), cdb_exp(2'd0, 7'd50, 32'd500)); end
    checks++; if (bus.fu_ready_out !== 3'b011) begin errors++; $display("FAIL ovf_ready: got %b exp 011", bus.fu_ready_out); end
    set_fu(2, 7'd54, 32'd504);
    step();
    clear_inputs();
    checks++; if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", bus.overflow_out); end
    checks++; if (cdb_now() !== cdb_exp(2'd1, 7'd51, 32'd501)) begin errors++; $display("FAIL ovf_fu1: got %h exp %h", cdb_now(), cdb_exp(2'd1, 7'd51, 32'd501)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd52, 32'd502)) begin errors++; $display("FAIL ovf_fu2a: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd52, 32'd502)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd53, 32'd503)) begin errors++; $display("FAIL ovf_fu2b: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd53, 32'd503)); end
    step();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %b exp 0", bus.cdb_valid_out); end
  endtask

  task automatic test_flush();
    set_fu(0, 7'd60, 32'd600); set_fu(1, 7'd61, 32'd601); set_fu(2, 7'd62, 32'd602);
    step();
    clear_inputs();
    set_fu(0, 7'd63, 32'd603); set_fu(1, 7'd64, 32'd604);
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd0, 7'd60, 32'd600)) begin errors++; $display("FAIL flush_pre: got %h exp %h", cdb_now(), cdb_exp(2'd0, 7'd60, 32'd600)); end
    clear_inputs();
    bus.flush_in = 1'b1;
    set_fu(1, 7'd65, 32'd605);
    step();
    bus.flush_in = 1'b0;
    clear_inputs();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", bus.cdb_valid_out); end
    checks++; if (bus.fu_ready_out !== 3'b111) begin errors++; $display("FAIL flush_ready: got %b exp 111", bus.fu_ready_out); end
    checks++; if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL flush_overflow: got %b exp 1", bus.overflow_out); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d: got %b exp 0", c, bus.cdb_valid_out); end
    end
    // Flush restarts round-robin at FU0.
    set_fu(0, 7'd70, 32'd700); set_fu(2, 7'd72, 32'd702);
    step();
    clear_inputs();
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd0, 7'd70, 32'd700)) begin errors++; $display("FAIL flush_rr0: got %h exp %h", cdb_now(), cdb_exp(2'd0, 7'd70, 32'd700)); end
    step();
    checks++; if (cdb_now() !== cdb_exp(2'd2, 7'd72, 32'd702)) begin errors++; $display("FAIL flush_rr2: got %h exp %h", cdb_now(), cdb_exp(2'd2, 7'd72, 32'd702)); end
    step();
  endtask

  task automatic test_reset_mid();
    set_fu(1, 7'd80, 32'd800);
    step();
    set_fu(1, 7'd81, 32'd801);
    step();
    clear_inputs();
    checks++; if (cdb_now() !== cdb_exp(2'd1, 7'd80, 32'd800)) begin errors++; $display("FAIL rstmid_pre: got %h exp %h", cdb_now(), cdb_exp(2'd1, 7'd80, 32'd800)); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cdb_now() !== 42'd0) begin errors++; $display("FAIL rstmid_cdb: got %h exp 0", cdb_now()); end
    checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b exp 0", bus.overflow_out); end
    checks++; if (bus.fu_ready_out !== 3'b111) begin errors++; $display("FAIL rstmid_ready: got %b exp 111", bus.fu_ready_out); end
    @(posedge clk); #1; rst = 1'b0;
    step();
    step();
    checks++; if (bus.cdb_valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_lost: got %b exp 0", bus.cdb_valid_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_fus();
    test_tag_zero();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
